// File: rtl/mux_interleave_2to1_if.sv
// ----------------------------------------------------------------------------
// mux_interleave_2to1_if
//   Bundles the two input lanes and the merged output stream of the 2:1
//   interleaver.
//
//   Signals:
//     data_in0/valid_in0/ready_in0 : lane 0 push handshake
//     data_in1/valid_in1/ready_in1 : lane 1 push handshake
//     data_out/valid_out/ready_out : merged output handshake
//
//   Modports:
//     slave  : the interleaver (consumes lanes, produces merged stream)
//     master : the environment (produces lanes, consumes merged stream)
// ----------------------------------------------------------------------------
interface mux_interleave_2to1_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] data_in0;
    logic                  valid_in0;
    logic                  ready_in0;
    logic [DATA_WIDTH-1:0] data_in1;
    logic                  valid_in1;
    logic                  ready_in1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  ready_out;

    modport slave (
        input  data_in0, valid_in0,
        output ready_in0,
        input  data_in1, valid_in1,
        output ready_in1,
        output data_out, valid_out,
        input  ready_out
    );

    modport master (
        output data_in0, valid_in0,
        input  ready_in0,
        output data_in1, valid_in1,
        input  ready_in1,
        input  data_out, valid_out,
        output ready_out
    );
endinterface

// File: rtl/mux_interleave_2to1.sv
// ----------------------------------------------------------------------------
// mux_interleave_2to1
//   Merges two lane word streams into one stream, alternating lane 0 and
//   lane 1. Each lane is buffered by a small FIFO; the output is a registered
//   valid/ready stage that holds its word under backpressure.
//
//   STRICT = 1 : strict 0,1,0,1 order; waits on an empty selected lane.
//   STRICT = 0 : work-conserving round robin between the two lanes.
//
//   Ports:
//     clk   : rising-edge clock for all state
//     reset : synchronous, active-high reset
//     bus   : lane inputs and merged output (mux_interleave_2to1_if.slave)
// ----------------------------------------------------------------------------
module mux_interleave_2to1 #(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 2,   // power of 2, at least 2
    parameter bit STRICT     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    mux_interleave_2to1_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    // Per-lane views of the interface so both lanes share one code path.
    logic [DATA_WIDTH-1:0] w_data_in [2];
    logic [1:0]            w_valid_in;
    logic [1:0]            w_ready_in;
    logic [1:0]            w_push;
    logic [1:0]            w_pop;
    logic [1:0]            w_nonempty;

    logic [DATA_WIDTH-1:0] r_mem    [2][FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr [2];
    logic [PTR_W-1:0]      r_rd_ptr [2];
    logic [CNT_W-1:0]      r_count  [2];

    logic                  r_sel;        // lane the arbiter prefers next
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;

    logic                  w_free;       // output register can take a word this edge
    logic                  w_pick;       // lane chosen for popping
    logic                  w_pick_valid; // a pop happens this edge

    assign w_data_in[0]  = bus.data_in0;
    assign w_data_in[1]  = bus.data_in1;
    assign w_valid_in[0] = bus.valid_in0;
    assign w_valid_in[1] = bus.valid_in1;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_lane
            // Ready depends only on the registered count, so a full lane
            // refuses a push even when it is popped in the same cycle.
            assign w_ready_in[g] = ~reset & (r_count[g] != FULL_CNT);
            assign w_nonempty[g] = (r_count[g] != '0);
            assign w_push[g]     = w_valid_in[g] & w_ready_in[g];
            assign w_pop[g]      = w_pick_valid & (w_pick == 1'(g));
        end
    endgenerate

    // The output register drains and refills on the same edge.
    assign w_free = ~r_valid_out | bus.ready_out;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        w_pick       = r_sel;
        w_pick_valid = 1'b0;
        if (w_nonempty[r_sel]) begin
            w_pick       = r_sel;
            w_pick_valid = w_free;
        end else if (!STRICT && w_nonempty[~r_sel]) begin
            // Work-conserving mode serves the other lane instead of idling.
            w_pick       = ~r_sel;
            w_pick_valid = w_free;
        end
    end

    // NOTE: the FIFO storage has no reset; the counts and pointers define
    // which entries are live, and leaving the array unreset lets it map to
    // plain registers or RAM without a reset network.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n]) begin
                r_mem[n][r_wr_ptr[n]] <= w_data_in[n];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                r_wr_ptr[n] <= '0;
                r_rd_ptr[n] <= '0;
                r_count[n]  <= '0;
            end
            r_sel       <= 1'b0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_push[n]) begin
                    r_wr_ptr[n] <= r_wr_ptr[n] + PTR_W'(1);
                end
                if (w_pop[n]) begin
                    r_rd_ptr[n] <= r_rd_ptr[n] + PTR_W'(1);
                end
                // Simultaneous push and pop leaves the count unchanged.
                r_count[n] <= r_count[n] + CNT_W'(w_push[n]) - CNT_W'(w_pop[n]);
            end

            if (w_free) begin
                if (w_pick_valid) begin
                    r_data_out  <= r_mem[w_pick][r_rd_ptr[w_pick]];
                    r_valid_out <= 1'b1;
                    // In strict mode w_pick equals r_sel, so this toggles;
                    // in round-robin mode it hands priority to the other lane.
                    r_sel       <= ~w_pick;
                end else begin
                    // data_out keeps its last value when nothing is popped.
                    r_valid_out <= 1'b0;
                end
            end
        end
    end

    assign bus.ready_in0 = w_ready_in[0];
    assign bus.ready_in1 = w_ready_in[1];
    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;

endmodule

// File: tb/tb_mux_interleave_2to1.sv
// ----------------------------------------------------------------------------
// tb_mux_interleave_2to1
//   Directed bench for mux_interleave_2to1. Two instances share clock, reset
//   and stimulus: dut_s (STRICT=1) and dut_w (STRICT=0). A table of per-cycle
//   vectors exercises the strict instance; hand-written sequences cover the
//   round-robin instance.
// ----------------------------------------------------------------------------
module tb_mux_interleave_2to1;
    localparam int DW = 4;

    typedef struct {
        logic          rst;
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          rdy;
        logic          e_r0;   // ready_in0 before the edge
        logic          e_r1;   // ready_in1 before the edge
        logic          e_vo;   // valid_out after the edge
        logic [DW-1:0] e_do;   // data_out after the edge
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];

    mux_interleave_2to1_if #(.DATA_WIDTH(DW)) if_s ();
    mux_interleave_2to1_if #(.DATA_WIDTH(DW)) if_w ();

    mux_interleave_2to1 #(.DATA_WIDTH(DW), .FIFO_DEPTH(2), .STRICT(1'b1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (if_s)
    );

    mux_interleave_2to1 #(.DATA_WIDTH(DW), .FIFO_DEPTH(2), .STRICT(1'b0)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (if_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rst, input logic v0, input logic [DW-1:0] d0,
                                input logic v1, input logic [DW-1:0] d1, input logic rdy,
                                input logic e_r0, input logic e_r1,
                                input logic e_vo, input logic [DW-1:0] e_do);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rdy = rdy;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_vo = e_vo; v.e_do = e_do;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Same stimulus goes to both instances.
    task automatic drive(input logic rst, input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1, input logic rdy);
        reset          = rst;
        if_s.valid_in0 = v0;  if_s.data_in0 = d0;
        if_s.valid_in1 = v1;  if_s.data_in1 = d1;
        if_s.ready_out = rdy;
        if_w.valid_in0 = v0;  if_w.data_in0 = d0;
        if_w.valid_in1 = v1;  if_w.data_in1 = d1;
        if_w.ready_out = rdy;
    endtask

    // One cycle on the round-robin instance: drive, edge, check output.
    task automatic step_w(input string tag, input logic v0, input logic [DW-1:0] d0,
                          input logic v1, input logic [DW-1:0] d1,
                          input logic e_vo, input logic [DW-1:0] e_do);
        drive(1'b0, v0, d0, v1, d1, 1'b1);
        @(posedge clk); #1;
        check({tag, " valid_out"}, 32'(if_w.valid_out), 32'(e_vo));
        check({tag, " data_out"},  32'(if_w.data_out),  32'(e_do));
    endtask

    initial begin
        // Columns: rst v0 d0 v1 d1 rdy | ready_in0 ready_in1 | valid_out data_out
        // Reset with lane0 driving 4'hA; nothing of it may survive.
        tbl.push_back(mk(1, 1, 4'hA, 0, 0, 1,  0, 0,  0, 4'h0));
        tbl.push_back(mk(1, 1, 4'hA, 0, 0, 1,  0, 0,  0, 4'h0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  0, 4'h0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  0, 4'h0));
        // Strict alternation 1..6; lane1 fills and 6 is retried.
        tbl.push_back(mk(0, 1, 1,    1, 2, 1,  1, 1,  0, 4'h0));
        tbl.push_back(mk(0, 1, 3,    1, 4, 1,  1, 1,  1, 4'h1));
        tbl.push_back(mk(0, 1, 5,    1, 6, 1,  1, 0,  1, 4'h2));
        tbl.push_back(mk(0, 0, 0,    1, 6, 1,  0, 1,  1, 4'h3));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 0,  1, 4'h4));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  1, 4'h5));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  1, 4'h6));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  0, 4'h6));
        // Lane1 silent: 7 leaves, 9 waits for lane1's 8.
        tbl.push_back(mk(0, 1, 7,    0, 0, 1,  1, 1,  0, 4'h6));
        tbl.push_back(mk(0, 1, 9,    0, 0, 1,  1, 1,  1, 4'h7));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  0, 4'h7));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  0, 4'h7));
        tbl.push_back(mk(0, 0, 0,    1, 8, 1,  1, 1,  0, 4'h7));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  1, 4'h8));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  1, 4'h9));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  0, 4'h9));
        // Realign selector to lane 0.
        tbl.push_back(mk(1, 0, 0,    0, 0, 1,  0, 0,  0, 4'h0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  0, 4'h0));
        // Backpressure for 5 cycles while both lanes keep pushing.
        tbl.push_back(mk(0, 1, 1,    1, 2, 0,  1, 1,  0, 4'h0));
        tbl.push_back(mk(0, 1, 3,    1, 4, 0,  1, 1,  1, 4'h1));
        tbl.push_back(mk(0, 1, 5,    1, 6, 0,  1, 0,  1, 4'h1));
        tbl.push_back(mk(0, 1, 7,    1, 6, 0,  0, 0,  1, 4'h1));
        tbl.push_back(mk(0, 1, 7,    1, 6, 0,  0, 0,  1, 4'h1));
        tbl.push_back(mk(0, 1, 7,    1, 6, 1,  0, 0,  1, 4'h2));
        tbl.push_back(mk(0, 1, 7,    1, 6, 1,  0, 1,  1, 4'h3));
        tbl.push_back(mk(0, 1, 7,    0, 0, 1,  1, 0,  1, 4'h4));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  0, 1,  1, 4'h5));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  1, 4'h6));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  1, 4'h7));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  0, 4'h7));
        // Fill both FIFOs with valid_out=1 and selector on lane 1, then reset.
        tbl.push_back(mk(0, 1, 1,    1, 2, 1,  1, 1,  0, 4'h7));
        tbl.push_back(mk(0, 1, 3,    1, 4, 1,  1, 1,  1, 4'h2));
        tbl.push_back(mk(0, 1, 5,    1, 6, 1,  0, 1,  1, 4'h1));
        tbl.push_back(mk(0, 1, 5,    0, 0, 0,  1, 0,  1, 4'h1));
        tbl.push_back(mk(1, 1, 7,    1, 8, 1,  0, 0,  0, 4'h0));
        // After reset: counts zero, lane0's fresh word wins.
        tbl.push_back(mk(0, 1, 9,    1, 4'hA, 1, 1, 1, 0, 4'h0));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  1, 4'h9));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  1, 4'hA));
        tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 1,  0, 4'hA));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].rdy);
            #1;
            check($sformatf("vec%0d ready_in0", i), 32'(if_s.ready_in0), 32'(tbl[i].e_r0));
            check($sformatf("vec%0d ready_in1", i), 32'(if_s.ready_in1), 32'(tbl[i].e_r1));
            @(posedge clk); #1;
            check($sformatf("vec%0d valid_out", i), 32'(if_s.valid_out), 32'(tbl[i].e_vo));
            check($sformatf("vec%0d data_out", i),  32'(if_s.data_out),  32'(tbl[i].e_do));
        end

        // Round-robin: lane1 alone streams 2,4,6 with no idle cycles.
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        @(posedge clk); #1;
        check("rr reset valid_out", 32'(if_w.valid_out), 32'(1'b0));
        step_w("rr push2", 1'b0, 4'h0, 1'b1, 4'h2, 1'b0, 4'h0);
        step_w("rr push4", 1'b0, 4'h0, 1'b1, 4'h4, 1'b1, 4'h2);
        step_w("rr push6", 1'b0, 4'h0, 1'b1, 4'h6, 1'b1, 4'h4);
        step_w("rr drain6", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h6);
        step_w("rr idle",  1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h6);
        // Selector now favours lane0; lane0 alone still streams, where the
        // strict arbiter would stall after the first word.
        step_w("rr l0 push1", 1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 4'h6);
        step_w("rr l0 push3", 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 4'h1);
        step_w("rr l0 out3",  1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h3);
        step_w("rr l0 idle",  1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
